// File: rtl/display_pkg.sv
// display_pkg -- shared constants for the multiplexed 4-digit display.
//   Segment patterns are active low, bit7 = decimal point (always off).
//   Anode patterns are active low, bit0 = rightmost digit.
//   Digit index: 0 = seconds ones, 1 = seconds tens,
//                2 = minutes ones, 3 = minutes tens.
package display_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] ANODE_S0  = 4'b1110;
    localparam logic [3:0] ANODE_S1  = 4'b1101;
    localparam logic [3:0] ANODE_M0  = 4'b1011;
    localparam logic [3:0] ANODE_M1  = 4'b0111;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    localparam logic [1:0] IDX_S0 = 2'd0;
    localparam logic [1:0] IDX_S1 = 2'd1;
    localparam logic [1:0] IDX_M0 = 2'd2;
    localparam logic [1:0] IDX_M1 = 2'd3;

endpackage

// File: rtl/display_scanner_if.sv
// display_scanner_if -- digit inputs and display outputs of display_scanner.
//   in_minute1/in_minute0/in_second1/in_second0 : BCD digits
//   in_adjust : adjust mode (enables blinking)
//   in_select : 1 = seconds pair blinks, 0 = minutes pair blinks
//   out_anode : active-low digit enables
//   out_seven_segment : active-low segments, bit7 = decimal point
//   master modport drives digits/controls, slave modport is the scanner.
interface display_scanner_if;
    logic [3:0] in_minute1;
    logic [3:0] in_minute0;
    logic [3:0] in_second1;
    logic [3:0] in_second0;
    logic       in_adjust;
    logic       in_select;
    logic [3:0] out_anode;
    logic [7:0] out_seven_segment;

    modport master (
        output in_minute1, in_minute0, in_second1, in_second0,
        output in_adjust, in_select,
        input  out_anode, out_seven_segment
    );

    modport slave (
        input  in_minute1, in_minute0, in_second1, in_second0,
        input  in_adjust, in_select,
        output out_anode, out_seven_segment
    );
endinterface

// File: rtl/segment_decoder.sv
// segment_decoder -- BCD digit to active-low seven-segment pattern.
//   in_bcd       : 4-bit digit; 10..15 decode to all segments off
//   out_segments : active-low segments, bit7 (decimal point) always off
module segment_decoder
    import display_pkg::*;
(
    input  logic [3:0] in_bcd,
    output logic [7:0] out_segments
);
    always_comb begin
        out_segments = SEG_BLANK;
        case (in_bcd)
            4'd0:    out_segments = SEG_0;
            4'd1:    out_segments = SEG_1;
            4'd2:    out_segments = SEG_2;
            4'd3:    out_segments = SEG_3;
            4'd4:    out_segments = SEG_4;
            4'd5:    out_segments = SEG_5;
            4'd6:    out_segments = SEG_6;
            4'd7:    out_segments = SEG_7;
            4'd8:    out_segments = SEG_8;
            4'd9:    out_segments = SEG_9;
            default: out_segments = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/display_scanner.sv
// display_scanner -- time-multiplexed driver for a 4-digit seven-segment
// display, with optional blinking of one digit pair in adjust mode.
//   in_clock : clock
//   in_reset : asynchronous active-high reset
//   bus      : display_scanner_if.slave (digits, adjust/select, anode/segments)
// Parameters:
//   SCAN_DIVIDE  : clock cycles per digit slot (>= 2)
//   BLINK_DIVIDE : clock cycles per blink half-period (>= 2)
// Build option:
//   DISPLAY_SCANNER_BLINK_EN : when defined, the selected pair blanks on
//   alternate blink phases while in_adjust is high; when undefined there is
//   no blink counter and in_adjust/in_select have no effect.
module display_scanner
    import display_pkg::*;
#(
    parameter int SCAN_DIVIDE  = 100000,
    parameter int BLINK_DIVIDE = 25000000
) (
    input  logic              in_clock,
    input  logic              in_reset,
    display_scanner_if.slave  bus
);
    localparam int SCAN_W = $clog2(SCAN_DIVIDE);

    logic [SCAN_W-1:0] scan_count;
    logic [1:0]        digit_index;
    logic [3:0]        digit_value;
    logic [3:0]        anode_next;
    logic [7:0]        digit_segments;
    logic              blank_slot;

    // Slot timer; the index steps on the last count of each slot.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            scan_count  <= '0;
            digit_index <= IDX_S0;
        end else if (scan_count == SCAN_W'(SCAN_DIVIDE - 1)) begin
            scan_count  <= '0;
            digit_index <= digit_index + 2'd1;
        end else begin
            scan_count  <= scan_count + 1'b1;
        end
    end

    always_comb begin
        digit_value = bus.in_second0;
        anode_next  = ANODE_S0;
        case (digit_index)
            IDX_S0: begin digit_value = bus.in_second0; anode_next = ANODE_S0; end
            IDX_S1: begin digit_value = bus.in_second1; anode_next = ANODE_S1; end
            IDX_M0: begin digit_value = bus.in_minute0; anode_next = ANODE_M0; end
            IDX_M1: begin digit_value = bus.in_minute1; anode_next = ANODE_M1; end
            default: begin digit_value = bus.in_second0; anode_next = ANODE_S0; end
        endcase
    end

    segment_decoder u_segment_decoder (
        .in_bcd       (digit_value),
        .out_segments (digit_segments)
    );

`ifdef DISPLAY_SCANNER_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIVIDE);

    logic [BLINK_W-1:0] blink_count;
    logic               blink_phase;

    // Held at zero outside adjust so every entry starts with a visible phase.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            blink_count <= '0;
            blink_phase <= 1'b0;
        end else if (!bus.in_adjust) begin
            blink_count <= '0;
            blink_phase <= 1'b0;
        end else if (blink_count == BLINK_W'(BLINK_DIVIDE - 1)) begin
            blink_count <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_count <= blink_count + 1'b1;
        end
    end

    // Index bit1 clear = seconds pair. in_adjust/in_select are used live so
    // a change reaches the display on the very next output edge.
    assign blank_slot = bus.in_adjust & blink_phase
                      & (digit_index[1] == ~bus.in_select);
`else
    assign blank_slot = 1'b0;
`endif

    // Output register: one cycle behind the index, digits sampled live here.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            bus.out_anode         <= ANODE_OFF;
            bus.out_seven_segment <= SEG_BLANK;
        end else begin
            bus.out_anode         <= anode_next;
            bus.out_seven_segment <= blank_slot ? SEG_BLANK : digit_segments;
        end
    end
endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIVIDE, default 100000, meaning in_clock cycles per digit slot (1 kHz slot rate at 100 MHz); legal range >=2.
REQ-002 SHALL have parameter BLINK_DIVIDE, default 25000000, meaning in_clock cycles per blink-phase half-period; legal range >=2.
REQ-003 Port: in_clock  input  1  the single clock.
REQ-004 Port: in_reset  input  1  asynchronous active-high reset.
REQ-005 Port: in_minute1 / in_minute0 / in_second1 / in_second0  input  4 each  BCD digits from the counter stage.
REQ-006 Port: in_adjust  input  1  adjust mode active; enables blinking.
REQ-007 Port: in_select  input  1  1 selects the seconds pair, 0 selects the minutes pair.
REQ-008 Port: out_anode  output  4  active-low digit enables; bit0 is rightmost.
REQ-009 Port: out_seven_segment  output  8  active-low segments; bit7 is the decimal point.

Function
REQ-010 Scan counter SHALL count 0..SCAN_DIVIDE-1, then wrap to 0; width SHALL be $clog2(SCAN_DIVIDE).
REQ-011 The 2-bit digit index SHALL advance 0->1->2->3->0 on the edge where the scan counter equals SCAN_DIVIDE-1.
REQ-012 The index-to-digit mapping SHALL be: 0=in_second0/anode 4'b1110, 1=in_second1/4'b1101, 2=in_minute0/4'b1011, 3=in_minute1/4'b0111.
REQ-013 out_anode and out_seven_segment SHALL be registered, each edge loading the pattern for the current index, giving exactly one cycle of latency from an index change.
REQ-014 Digit inputs SHALL be sampled live at the output-register edge and SHALL NOT be latched elsewhere.
REQ-015 Decode SHALL be 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex); values 10..15 SHALL produce FF.
REQ-016 The decimal point (bit7) SHALL always be 1 (off).
REQ-017 The blink counter SHALL count 0..BLINK_DIVIDE-1 while in_adjust=1 and toggle the blink phase on wrap.
REQ-018 While in_adjust=0, the blink counter and phase SHALL be held at 0, so entry into adjust shows digits for the first BLINK_DIVIDE cycles.
REQ-019 While in_adjust=1 and phase=1, slots of the selected pair SHALL output segments FF with their anode still asserted; the other pair SHALL be unaffected.
REQ-020 A change of in_select mid-phase SHALL take effect on the next output-register edge without resetting the blink counter.
REQ-021 Exactly one bit of out_anode SHALL be 0 at all times after the first post-reset edge.

Reset
REQ-022 Asserting in_reset SHALL immediately force the scan counter, index, blink counter and phase to 0, out_anode to 4'b1111, and out_seven_segment to 8'hFF.
REQ-023 Reset asserted mid-scan or mid-blink SHALL discard progress; the first edge after release SHALL drive anode 4'b1110 with the in_second0 decode.

Configuration
REQ-024 Macro DISPLAY_SCANNER_BLINK_EN defined: blink logic per REQ-017..REQ-020 SHALL be present.
REQ-025 Macro DISPLAY_SCANNER_BLINK_EN undefined: no blink counter SHALL be present, in_adjust and in_select SHALL be ignored, and all slots SHALL always decode.

Structure
REQ-026 Shared package display_pkg SHALL hold the ten digit segment constants, SEG_BLANK=8'hFF, the four anode patterns, and the digit index localparams.
REQ-027 Combinational sub-module segment_decoder (4-bit BCD in, 8-bit segments out) SHALL implement REQ-015/REQ-016, with one instance.

Verification (bench uses SCAN_DIVIDE=4, BLINK_DIVIDE=16, DISPLAY_SCANNER_BLINK_EN defined)
REQ-028 Digits m1=1,m0=2,s1=3,s0=4, adjust=0 -> anode sequence 1110,1101,1011,0111 every 4 cycles with segments 99,B0,A4,F9.
REQ-029 in_second0=4'hC -> slot 0 segments FF, anode 1110 still asserted.
REQ-030 adjust=1, select=1 -> slots 0/1 show digits for 16 cycles, then FF for 16 cycles, repeating; slots 2/3 never blank.
REQ-031 adjust=1, select=0, then adjust dropped mid-blank-phase -> minutes visible from next edge; re-entry gives a full 16-cycle visible phase.
REQ-032 in_reset pulsed while index=2 -> outputs 1111/FF asynchronously; first edge after release gives 1110 with the s0 decode.
REQ-033 Build without DISPLAY_SCANNER_BLINK_EN, adjust=1 -> no slot ever blanks across 64 cycles.
